// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, WAIT_CYCLES wait states; DMEM_ERR_CHECK_EN adds fault checking.
// resp_valid rises WAIT_CYCLES edges after the accepting edge; RESP is held until resp_ready, req_ready only in IDLE.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [15:0] busy_cycles
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          accept;
   logic          enter_resp;
   logic          acc_we;
   logic          acc_err;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [AW-1:0] acc_idx;

   // With no wait states the access completes on the accepting edge, so it uses the live request.
   assign acc_we    = (state == S_IDLE) ? req_we    : we_q;
   assign acc_addr  = (state == S_IDLE) ? req_addr  : addr_q;
   assign acc_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
   assign acc_idx   = acc_addr[AW+1:2];

   assign accept     = (state == S_IDLE) && req_valid;
   assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));

`ifdef DMEM_ERR_CHECK_EN
   assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
`else
   logic unused_addr;
   assign acc_err     = 1'b0;
   assign unused_addr = ^{acc_addr[31:AW+2], acc_addr[1:0]};
`endif

   // The array sits in the reset block only to share the commit condition; reset never touches it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= 4'd0;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'd0;
         resp_err    <= 1'b0;
         busy_cycles <= 16'd0;
         we_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
      end else begin
         if ((state != S_IDLE) && (busy_cycles != 16'hFFFF)) begin
            busy_cycles <= busy_cycles + 16'd1;
         end
         if (enter_resp) begin
            if (acc_we && !acc_err) begin
               mem[acc_idx] <= acc_wdata;
            end
            resp_rdata <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
            resp_err   <= acc_err;
         end
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  state      <= S_IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  resp_rdata <= 32'd0;
                  resp_err   <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance a has two wait states, instance b has none.
`timescale 1ns/1ps
module tb_dmem_responder;

   logic        clk;
   logic        reset;

   logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
   logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
   logic [15:0] a_busy;
   logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
   logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
   logic [15:0] b_busy;

   int errors = 0;
   int checks = 0;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_a (
      .clk(clk), .reset(reset),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
      .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy_cycles(a_busy)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_b (
      .clk(clk), .reset(reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy_cycles(b_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Called at a negedge with the DUT idle and resp_ready=1; lat counts edges after the accepting edge.
   task automatic a_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er, output int lat, output time t_acc);
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      a_req_valid = 1'b0; a_req_we = ~we; a_req_addr = addr ^ 32'h4; a_req_wdata = ~wdata;
      lat = 0;
      while (!a_resp_valid && lat < 50) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      rd = a_resp_rdata; er = a_resp_err;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic b_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er, output int lat, output time t_acc);
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      b_req_valid = 1'b0; b_req_we = ~we; b_req_addr = addr ^ 32'h4; b_req_wdata = ~wdata;
      lat = 0;
      while (!b_resp_valid && lat < 50) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      rd = b_resp_rdata; er = b_resp_err;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", a_req_ready); end
      checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", a_resp_valid); end
      checks++; if (a_resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", a_resp_rdata); end
      checks++; if (a_resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", a_resp_err); end
      checks++; if (a_busy !== 16'd0 || b_busy !== 16'd0) begin errors++; $display("FAIL reset_busy: got %h/%h want 0/0", a_busy, b_busy); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] rd; logic er; int lat; time t0, t1;
      a_access(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, t0);
      checks++; if (lat !== 2) begin errors++; $display("FAIL basic_store_lat: got %0d want 2", lat); end
      checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL basic_store_resp: got %h/%b want 0/0", rd, er); end
      a_access(1'b0, 32'h10, 32'h0, rd, er, lat, t1);
      checks++; if (lat !== 2) begin errors++; $display("FAIL basic_load_lat: got %0d want 2", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_load_rdata: got %h want deadbeef", rd); end
      checks++; if (t1 - t0 !== 40) begin errors++; $display("FAIL basic_throughput: got %0t want 40", t1 - t0); end
      checks++; if (a_busy !== 16'd6) begin errors++; $display("FAIL basic_busy: got %0d want 6", a_busy); end
   endtask

   task automatic test_wait0();
      logic [31:0] rd; logic er; int lat; time t0, t1;
      b_access(1'b1, 32'h0, 32'h12345678, rd, er, lat, t0);
      checks++; if (lat !== 0) begin errors++; $display("FAIL w0_store_lat: got %0d want 0", lat); end
      b_access(1'b0, 32'h0, 32'h0, rd, er, lat, t1);
      checks++; if (lat !== 0) begin errors++; $display("FAIL w0_load_lat: got %0d want 0", lat); end
      checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL w0_load_rdata: got %h want 12345678", rd); end
      checks++; if (t1 - t0 !== 20) begin errors++; $display("FAIL w0_throughput: got %0t want 20", t1 - t0); end
      checks++; if (b_busy !== 16'd2) begin errors++; $display("FAIL w0_busy: got %0d want 2", b_busy); end
   endtask

   task automatic test_stall();
      logic [31:0] rd; logic er; int lat; time t0; int n;
      a_resp_ready = 1'b0;
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10;
      @(posedge clk);
      @(negedge clk);
      a_req_we = 1'b1; a_req_wdata = 32'hBAD0BAD0;
      n = 0;
      while (!a_resp_valid && n < 20) begin @(negedge clk); n++; end
      checks++; if (n !== 2) begin errors++; $display("FAIL stall_lat: got %0d want 2", n); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (a_resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, a_resp_valid); end
         checks++; if (a_resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_rdata[%0d]: got %h want deadbeef", i, a_resp_rdata); end
         checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, a_req_ready); end
         @(negedge clk);
      end
      a_resp_ready = 1'b1; a_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got valid=%b ready=%b want 0/1", a_resp_valid, a_req_ready); end
      checks++; if (a_resp_rdata !== 32'd0) begin errors++; $display("FAIL stall_rdata_clear: got %h want 0", a_resp_rdata); end
      a_access(1'b0, 32'h10, 32'h0, rd, er, lat, t0);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_no_store: got %h want deadbeef", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat; time t0;
      a_access(1'b1, 32'h20, 32'h0000AAAA, rd, er, lat, t0);
      b_resp_ready = 1'b0;
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h00005555;
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h0;
      @(posedge clk);
      @(negedge clk);
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      checks++; if (b_resp_rdata !== 32'h12345678) begin errors++; $display("FAIL rmid_pre_rdata: got %h want 12345678", b_resp_rdata); end
      #2 reset = 1'b1;
      #1;
      checks++; if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_a_hs: got ready=%b valid=%b want 1/0", a_req_ready, a_resp_valid); end
      checks++; if (a_busy !== 16'd0) begin errors++; $display("FAIL rmid_a_busy: got %0d want 0", a_busy); end
      checks++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1) begin errors++; $display("FAIL rmid_b_hs: got valid=%b ready=%b want 0/1", b_resp_valid, b_req_ready); end
      checks++; if (b_resp_rdata !== 32'd0) begin errors++; $display("FAIL rmid_b_rdata: got %h want 0", b_resp_rdata); end
      @(negedge clk);
      reset = 1'b0; b_resp_ready = 1'b1;
      a_access(1'b0, 32'h20, 32'h0, rd, er, lat, t0);
      checks++; if (rd !== 32'h0000AAAA) begin errors++; $display("FAIL rmid_discard: got %h want 0000aaaa", rd); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL rmid_lat: got %0d want 2", lat); end
   endtask

   task automatic test_alias();
      logic [31:0] rd; logic er; int lat; time t0;
`ifdef DMEM_ERR_CHECK_EN
      b_access(1'b0, 32'h2, 32'h0, rd, er, lat, t0);
      checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_misaligned: got err=%b rdata=%h want 1/0", er, rd); end
      checks++; if (lat !== 0) begin errors++; $display("FAIL err_lat: got %0d want 0", lat); end
      b_access(1'b1, 32'h400, 32'hFFFF0000, rd, er, lat, t0);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_range: got %b want 1", er); end
      b_access(1'b0, 32'h0, 32'h0, rd, er, lat, t0);
      checks++; if (rd !== 32'h12345678 || er !== 1'b0) begin errors++; $display("FAIL err_unchanged: got %h/%b want 12345678/0", rd, er); end
`else
      b_access(1'b1, 32'h400, 32'hCAFEF00D, rd, er, lat, t0);
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL alias_store_err: got %b want 0", er); end
      b_access(1'b0, 32'h0, 32'h0, rd, er, lat, t0);
      checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_wrap: got %h want cafef00d", rd); end
      b_access(1'b0, 32'h3, 32'h0, rd, er, lat, t0);
      checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL alias_lowbits: got %h/%b want cafef00d/0", rd, er); end
`endif
   endtask

   task automatic test_busy_sat();
      checks++; if (b_busy !== 16'd3) begin errors++; $display("FAIL busy_pre: got %0d want 3", b_busy); end
      b_resp_ready = 1'b0;
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h0;
      @(posedge clk);
      @(negedge clk);
      b_req_valid = 1'b0;
      repeat (70000) @(posedge clk);
      @(negedge clk);
      checks++; if (b_busy !== 16'hFFFF) begin errors++; $display("FAIL busy_saturate: got %h want ffff", b_busy); end
      checks++; if (b_resp_valid !== 1'b1) begin errors++; $display("FAIL busy_held: got %b want 1", b_resp_valid); end
      b_resp_ready = 1'b1;
      @(negedge clk);
      checks++; if (b_busy !== 16'hFFFF || b_req_ready !== 1'b1) begin errors++; $display("FAIL busy_after: got %h/%b want ffff/1", b_busy, b_req_ready); end
   endtask

   initial begin
      reset = 1'b1;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'd0; a_req_wdata = 32'd0; a_resp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0; b_resp_ready = 1'b1;
      test_reset();
      test_basic();
      test_wait0();
      test_stall();
      test_reset_mid();
      test_alias();
      test_busy_sat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two, 4..4096.
REQ-002 Parameter WAIT_CYCLES, default 2: added wait states per access, 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator (MEM stage) presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  initiator consumes the response this cycle.
REQ-012 resp_rdata  output  32  load data; 0 for stores and errored accesses.
REQ-013 resp_err  output  1  access faulted (only with REQ-033 macro defined).
REQ-014 busy_cycles  output  16  saturating count of cycles spent outside IDLE.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; req_ready is 1 only in IDLE; resp_valid is 1 only in RESP.
REQ-016 Accept: rising edge with state IDLE and req_valid=1; req_we, req_addr and req_wdata are registered at that edge and later input changes are ignored.
REQ-017 On accept, the next state is WAIT with counter = WAIT_CYCLES-1 when WAIT_CYCLES>0, otherwise RESP.
REQ-018 In WAIT, the counter decrements each edge; the state moves to RESP on the edge where counter=0.
REQ-019 Latency: resp_valid rises right after the WAIT_CYCLES-th edge following the accepting edge (WAIT_CYCLES=0: right after the accepting edge).
REQ-020 Word index = registered addr[log2(DEPTH_WORDS)+1:2].
REQ-021 Store commits to the array on the edge entering RESP; a load samples the array on that same edge.
REQ-022 A load issued after a store to the same word returns the stored value.
REQ-023 resp_rdata and resp_err are stable throughout RESP.
REQ-024 In RESP with resp_ready=1: next state is IDLE, and resp_rdata and resp_err clear to 0.
REQ-025 In RESP with resp_ready=0: state holds indefinitely.
REQ-026 No request is accepted in the same cycle a response is consumed; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-027 req_valid while req_ready=0 has no effect.
REQ-028 busy_cycles increments every cycle the state is WAIT or RESP and saturates at 16'hFFFF.

Reset
REQ-029 Reset asserted, including mid-access, forces the following immediately, regardless of clk: state IDLE, counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy_cycles=0.
REQ-030 A store still in WAIT when reset asserts is discarded and does not commit.
REQ-031 Reset does not clear array contents.
REQ-032 The first accept occurs on the first rising edge after reset deasserts with req_valid=1.

Configuration
REQ-033 Macro DMEM_ERR_CHECK_EN defined: addr[1:0]!=0 or addr>=4*DEPTH_WORDS sets resp_err=1 in RESP, suppresses the store, forces resp_rdata=0, and keeps latency unchanged.
REQ-034 Macro DMEM_ERR_CHECK_EN undefined: resp_err is tied 0, addr[1:0] is ignored, and the address wraps modulo DEPTH_WORDS.

Verification
REQ-035 WAIT_CYCLES=2, resp_ready=1: store addr 0x10 data 0xDEADBEEF, then load 0x10 -> rdata 0xDEADBEEF, resp_valid 2 edges after each accept, 4 cycles per access.
REQ-036 WAIT_CYCLES=0: load right after store to 0x0 data 0x12345678 -> resp_valid the cycle after accept, rdata 0x12345678.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP with req_valid=1 -> resp_valid and rdata stable, req_ready=0, no new accept; resp_ready=1 -> IDLE next cycle.
REQ-038 Store 0x0000AAAA to 0x20, then reset asserted during WAIT of a store 0x5555 to 0x20 -> outputs cleared immediately; a following load of 0x20 returns 0x0000AAAA.
REQ-039 With DMEM_ERR_CHECK_EN: load 0x2 -> resp_err=1, rdata 0; store to 0x400 (DEPTH 256) -> resp_err=1, array unchanged. Without the macro: 0x400 aliases 0x0.
REQ-040 Run 70000 accesses -> busy_cycles saturates at 0xFFFF and does not wrap.
